lo_mix_accum: RTL and testbench

Mixes a signed ADC sample stream against the sin/cos local oscillator produced by `rot_dds` and integrates each product over a programmable number of samples. The result is one I/Q pair per integration block. It sits directly downstream of `rot_dds`, which drives its `cosa`/`sina` inputs, and feeds the feedback/readout logic through a valid/ready output port. Block length matches the DDS modulo period, for example 13 samples for a 9/13 LO, so each block spans an integer number of LO cycles and the DC leakage cancels.

---
 rtl/lo_mix_accum.sv | 133 +++++++++++++
 tb/tb_lo_mix_accum.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lo_mix_accum.sv
// LO mixer and block integrator: multiplies ADC samples by the DDS sin/cos
// and dumps one I/Q pair per block of P accepted samples.
module lo_mix_accum #(
  parameter int DW = 16,
  parameter int LW = 18,
  parameter int NW = 8,
  parameter int OW = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic signed [DW-1:0] adc,
  input  logic signed [LW-1:0] cosa,
  input  logic signed [LW-1:0] sina,
  input  logic        [NW-1:0] period,
  output logic signed [OW-1:0] i_out,
  output logic signed [OW-1:0] q_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int PW = DW + LW;
  localparam int AW = PW + NW;

  logic        [NW-1:0] cnt;
  logic        [NW-1:0] p_reg;
  logic        [NW-1:0] p_eff;
  logic        [NW-1:0] p_m1;
  logic                 p_ld;
  logic                 last0;

  logic signed [PW-1:0] pi;
  logic signed [PW-1:0] pq;
  logic                 v1;
  logic                 last1;

  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum_i;
  logic signed [AW-1:0] sum_q;
  logic signed [OW-1:0] r_i;
  logic signed [OW-1:0] r_q;
  logic                 d2;

  // Until the first latch after reset, the live period input is used.
  assign p_eff = p_ld ? p_reg : period;
  assign p_m1  = p_eff - {{(NW-1){1'b0}}, 1'b1};
  assign last0 = (cnt == p_m1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      p_reg <= '0;
      p_ld  <= 1'b0;
    end else begin
      p_ld <= 1'b1;
      if (!p_ld) p_reg <= period;
      if (enable) begin
        if (last0) begin
          cnt   <= '0;
          p_reg <= period;
        end else begin
          cnt <= cnt + {{(NW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pi    <= '0;
      pq    <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      pi    <= adc * cosa;
      pq    <= adc * sina;
      v1    <= enable;
      last1 <= enable && last0;
    end
  end

  always_comb begin
    sum_i = acc_i + {{NW{pi[PW-1]}}, pi};
    sum_q = acc_q + {{NW{pq[PW-1]}}, pq};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_i <= '0;
      acc_q <= '0;
      r_i   <= '0;
      r_q   <= '0;
      d2    <= 1'b0;
    end else begin
      d2 <= 1'b0;
      if (v1) begin
        if (last1) begin
          acc_i <= '0;
          acc_q <= '0;
          r_i   <= sum_i[AW-1 -: OW];
          r_q   <= sum_q[AW-1 -: OW];
          d2    <= 1'b1;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
  end

  // A new result replaces any pending one; flag it if it was never taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (d2) begin
        i_out     <= r_i;
        q_out     <= r_q;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lo_mix_accum.sv
// Scoreboard bench for lo_mix_accum: a block-sum reference model feeds a
// queue that an independent output monitor drains.
module tb_lo_mix_accum;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] adc = '0;
  logic signed [17:0] cosa = '0;
  logic signed [17:0] sina = '0;
  logic        [7:0]  period = 8'd4;
  logic signed [23:0] i_out;
  logic signed [23:0] q_out;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               overrun;

  lo_mix_accum dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc(adc),
    .cosa(cosa), .sina(sina), .period(period), .i_out(i_out),
    .q_out(q_out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { longint i; longint q; } res_t;
  res_t   expq[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     n_res = 0;
  int     n_ovr = 0;
  longint last_i = 0;
  longint last_q = 0;

  longint m_ai, m_aq;
  int     m_cnt, m_len;

  function automatic int plen(input logic [7:0] p);
    return (p == 8'd0) ? 256 : int'(p);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint fl24(input longint s);
    longint t;
    t = s >>> 18;
    return longint'($signed(t[23:0]));
  endfunction

  // Reference: sum exact products over each block, floor-divide by 2^18.
  task automatic model_accept();
    res_t r;
    m_ai += longint'(adc) * longint'(cosa);
    m_aq += longint'(adc) * longint'(sina);
    m_cnt++;
    if (m_cnt == m_len) begin
      r.i = fl24(m_ai);
      r.q = fl24(m_aq);
      expq.push_back(r);
      m_ai = 0; m_aq = 0; m_cnt = 0;
      m_len = plen(period);
    end
  endtask

  task automatic step(input logic en, input int a, input int c,
                      input int s, input int per, input logic rdy);
    enable = en; adc = 16'(a); cosa = 18'(c); sina = 18'(s);
    period = 8'(per); out_ready = rdy;
    @(posedge clk);
    if (en) model_accept();
    #1;
  endtask

  task automatic do_reset(input int per);
    reset_n = 1'b0;
    enable = 1'b0;
    period = 8'(per);
    expq.delete();
    m_ai = 0; m_aq = 0; m_cnt = 0;
    #1;
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_len = plen(period);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    enable = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((expq.size() != 0 || out_valid) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (overrun) begin
        n_ovr++;
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got i=%0d q=%0d", i_out, q_out);
        end else begin
          res_t e;
          e = expq.pop_front();
          chk("sb_i", i_out, e.i);
          chk("sb_q", q_out, e.q);
        end
        last_i = i_out;
        last_q = q_out;
        n_res++;
      end
    end
  end

  initial begin
    int r0, o0, per;
    logic en;
    repeat (3) @(posedge clk);
    #1;
    do_reset(4);

    // DC/cos block of 4
    r0 = n_res;
    for (int k = 0; k < 12; k++) step(1, 1000, 131071, 0, 4, 1);
    drain();
    chk("dc_blocks", n_res - r0, 3);
    chk("dc_i", last_i, 1999);
    chk("dc_q", last_q, 0);

    // latency with P=1
    do_reset(1);
    step(1, 300, 5000, -7000, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("lat_t1_valid", out_valid, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("lat_t2_valid", out_valid, 1);
    drain();

    // P=1 back-to-back: accept with dump each cycle, no overrun
    do_reset(1);
    o0 = n_ovr;
    for (int k = 0; k < 10; k++) step(1, $urandom, $urandom, $urandom, 1, 1);
    chk("p1_valid_hold", out_valid, 1);
    drain();
    chk("p1_no_ovr", n_ovr - o0, 0);

    // backpressure: three dumps with nobody listening
    do_reset(2);
    o0 = n_ovr;
    for (int k = 0; k < 6; k++) step(1, 100 * (k + 1), 65536, -65536, 2, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 2, 0);
    chk("bp_ovr", n_ovr - o0, 2);
    drain();
    chk("bp_latest_i", last_i, fl24(longint'(1100) * 65536));

    // period change mid-block plus enable gaps
    do_reset(4);
    r0 = n_res;
    step(1, 1234, 40000, 30000, 4, 1);
    step(1, -999, 40000, 30000, 4, 1);
    for (int k = 0; k < 20; k++)
      step(k[0], 500 + k, -60000, 20000, 7, 1);
    drain();
    chk("gap_blocks", n_res - r0, 2);

    // extreme values, 256-sample block
    do_reset(0);
    for (int k = 0; k < 256; k++) step(1, -32768, -131072, 131071, 0, 1);
    drain();
    chk("ext_i", last_i, 4194304);
    chk("ext_q", last_q, -4194272);

    // reset mid-block: partial block discarded, restart from release
    do_reset(13);
    for (int k = 0; k < 3; k++) step(1, 20000, 100000, 5, 13, 1);
    r0 = n_res;
    do_reset(13);
    for (int k = 0; k < 12; k++) step(1, 777, -3333, 1111, 13, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 13, 1);
    chk("rst_no_early", n_res - r0, 0);
    step(1, 777, -3333, 1111, 13, 1);
    drain();
    chk("rst_block", n_res - r0, 1);
    chk("rst_block_i", last_i, fl24(longint'(777) * -3333 * 13));

    // random soak
    do_reset(3);
    per = 3;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 40) == 0) begin
        case ($urandom_range(0, 5))
          0: per = 1;
          1: per = 2;
          2: per = 5;
          3: per = 13;
          4: per = 0;
          default: per = 7;
        endcase
      end
      en = ($urandom_range(0, 3) != 0);
      step(en, $urandom, $urandom, $urandom, per,
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
